// File: rtl/cordic_result_sched.sv
// cordic_result_sched: admits CORDIC starts against a result-slot credit,
// follows each angle through the fixed-latency pipeline, queues the sin/cos
// results and streams them to uart_tx as framed byte packets.
module cordic_result_sched #(
    parameter int          DATA_W      = 48,
    parameter int          LATENCY     = 50,
    parameter int          DEPTH       = 4,
    parameter logic [7:0]  BYTE_HEADER = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cordic_start,
    input  logic              i_pipeline_en,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_sin,
    input  logic [DATA_W-1:0] i_cos,
    output logic              o_start_ready,
    output logic              o_cordic_go,
    output logic              o_drop,
    output logic [7:0]        o_drop_cnt,
    output logic [7:0]        o_tx_byte,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy
);

    localparam int CW     = $clog2(DEPTH + 1);
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB     = DATA_W / 8;
    localparam int NBYTES = 2 * NB;
    localparam int IW     = $clog2(NBYTES + 1);
    localparam int WW     = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } state_t;

    logic [LATENCY-1:0] trk_q, trk_d, trk_shift;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      fifo_count_q, fifo_count_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [WW-1:0]      mem_q [DEPTH];
    logic [WW-1:0]      mem_d [DEPTH];
    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               drop_q, drop_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic               start_ready;
    logic               accept;
    logic               retire;
    logic               push;
    logic               pop;
    logic               handshake;
    logic               last_byte;
    logic [CW:0]        credit_used;
    logic [WW-1:0]      head_word;

    // Pick byte k of a stored {cos, sin} word: sin bytes first, LSB first.
    function automatic logic [7:0] byte_sel(input logic [WW-1:0] w, input logic [IW-1:0] k);
        return w[8*k +: 8];
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Shift path of the in-flight tracker; a one-stage pipeline has no history.
    generate
        if (LATENCY == 1) begin : g_trk_one
            assign trk_shift = accept;
        end else begin : g_trk_many
            assign trk_shift = {trk_q[LATENCY-2:0], accept};
        end
    endgenerate

    // Credit check, admission, retirement and drop bookkeeping.
    always_comb begin
        credit_used = {1'b0, inflight_q} + {1'b0, fifo_count_q};
        start_ready = i_pipeline_en && !i_flush && (credit_used < (CW+1)'(DEPTH));
        accept      = i_cordic_start && start_ready;
        retire      = trk_q[LATENCY-1] && i_pipeline_en;
        push        = retire && !i_flush;
        drop_d      = i_cordic_start && !start_ready && !i_flush;
        drop_cnt_d  = (drop_d && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;

        trk_d = trk_q;
        if (i_flush) begin
            trk_d = '0;
        end else if (i_pipeline_en) begin
            trk_d = trk_shift;
        end

        if (i_flush) begin
            inflight_d = '0;
        end else begin
            inflight_d = inflight_q + CW'(accept) - CW'(retire);
        end
    end

    // Result FIFO: pointers, occupancy and the storage write on retire.
    always_comb begin
        handshake = tx_valid_q && i_tx_ready;
        last_byte = (idx_q == IW'(NBYTES - 1));
        pop       = (state_q == ST_DATA) && handshake && last_byte && !i_flush;
        head_word = mem_q[rd_ptr_q];

        if (i_flush) begin
            fifo_count_d = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end else begin
            fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
            wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        end

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (push && (wr_ptr_q == PW'(i))) ? {i_cos, i_sin} : mem_q[i];
        end
    end

    // TX framing: header, then sin bytes, then cos bytes; byte held while stalled.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        if (i_flush) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            tx_byte_d  = 8'h00;
            tx_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_valid_d = 1'b0;
                    if (fifo_count_q != '0) begin
                        state_d    = ST_HDR;
                        tx_valid_d = 1'b1;
                        tx_byte_d  = BYTE_HEADER;
                    end
                end
                ST_HDR: begin
                    if (handshake) begin
                        state_d   = ST_DATA;
                        idx_d     = '0;
                        tx_byte_d = byte_sel(head_word, '0);
                    end
                end
                ST_DATA: begin
                    if (handshake) begin
                        if (last_byte) begin
                            // Returning through IDLE guarantees one gap cycle between frames.
                            state_d    = ST_IDLE;
                            idx_d      = '0;
                            tx_valid_d = 1'b0;
                            tx_byte_d  = 8'h00;
                        end else begin
                            idx_d     = idx_q + 1'b1;
                            tx_byte_d = byte_sel(head_word, idx_q + 1'b1);
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    idx_d      = '0;
                    tx_valid_d = 1'b0;
                    tx_byte_d  = 8'h00;
                end
            endcase
        end
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            trk_q        <= '0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            tx_valid_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            drop_q       <= 1'b0;
            drop_cnt_q   <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            trk_q        <= trk_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            tx_valid_q   <= tx_valid_d;
            tx_byte_q    <= tx_byte_d;
            drop_q       <= drop_d;
            drop_cnt_q   <= drop_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign o_start_ready = start_ready;
    assign o_cordic_go   = accept;
    assign o_drop        = drop_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_tx_byte     = tx_byte_q;
    assign o_tx_valid    = tx_valid_q;
    assign o_busy        = (inflight_q != '0) || (fifo_count_q != '0) || (state_q != ST_IDLE);

endmodule
